// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Serial byte-stream loader for a 256 x 32 instruction memory.
//            Bytes are packed little-endian into words, written once per word,
//            and the core is held while a session runs.
//            Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  load_len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHK   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_byte_cnt;
  logic [8:0]  r_words_left;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic        w_start_ok;
  logic        w_take_data;
  logic        w_last_word;

  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_take_data = (r_state == S_RECV) && byte_valid;
  assign w_last_word = (r_words_left == 9'd1);

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    core_hold  = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (load_len == 9'd0) ? S_FIN : S_RECV;
        end
      end
      S_RECV: begin
        byte_ready = 1'b1;
        core_hold  = 1'b1;
        if (byte_valid && (r_byte_cnt == 2'd3)) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        core_hold = 1'b1;
        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_FIN;
`endif
        end else begin
          w_next = S_RECV;
        end
      end
      S_CHK: begin
        core_hold = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_ready = 1'b1;
        if (byte_valid) begin
          w_next = S_FIN;
        end
`else
        w_next = S_FIN;
`endif
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Bytes shift in from the top so the first byte ends up in bits 7:0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt   <= 2'd0;
      r_words_left <= 9'd0;
      r_addr       <= 8'd0;
      r_wdata      <= 32'd0;
    end else begin
      if (w_start_ok) begin
        r_byte_cnt   <= 2'd0;
        r_words_left <= load_len;
        r_addr       <= 8'd0;
      end
      if (w_take_data) begin
        r_wdata    <= {byte_data, r_wdata[31:8]};
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (r_state == S_WRITE) begin
        r_addr       <= r_addr + 8'd1;
        r_words_left <= r_words_left - 9'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xor <= 8'd0;
      r_err <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_xor <= 8'd0;
        r_err <= 1'b0;
      end
      if (w_take_data) begin
        r_xor <= r_xor ^ byte_data;
      end
      if ((r_state == S_CHK) && byte_valid && (byte_data != r_xor)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Randomized self-checking bench for imem_loader against a
//            word-level reference model built from the byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] byte_q[$];

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit c_CK_EN = 1'b1;
`else
  localparam bit c_CK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  imem_loader u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int len);
    byte_q.delete();
    for (int i = 0; i < 4 * len; i++) byte_q.push_back(8'($urandom));
  endtask

  task automatic fill_incr(input int len);
    byte_q.delete();
    for (int i = 0; i < len; i++) begin
      byte_q.push_back(8'(i));
      byte_q.push_back(8'h00);
      byte_q.push_back(8'h00);
      byte_q.push_back(8'h00);
    end
  endtask

  // mode: 0 = no stalls, 1 = valid every other cycle, 2 = random valid
  task automatic run_session(input int len, input int mode, input int abort_after, input bit bad_ck);
    logic [7:0]  ck;
    logic [31:0] w;
    int ptr, writes, c, done_at, done_c, budget, quiet;
    bit bv, ck_sent, saw_done, exp_err;
    ck = 8'h00;
    foreach (byte_q[i]) ck = ck ^ byte_q[i];
    if (bad_ck) ck = ck ^ 8'h01;
    ptr = 0; writes = 0; c = 0; ck_sent = 0; saw_done = 0; done_c = -1;
    done_at = (len == 0) ? 0 : -1;
    budget  = 40 * len + 40;
    load_len = 9'(len); start = 1'b1; byte_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    while (!saw_done && c <= budget) begin
      if (mem_we) begin
        if (writes < len) begin
          w = {byte_q[4*writes+3], byte_q[4*writes+2], byte_q[4*writes+1], byte_q[4*writes]};
          chk("waddr", 32'(mem_addr), 32'(writes));
          chk("wdata", mem_wdata, w);
          chk("ready_in_write", 32'(byte_ready), 32'd0);
        end else begin
          chk("extra_write", 32'(writes + 1), 32'(len));
        end
        writes++;
        if (writes == len && !c_CK_EN) done_at = c + 1;
      end
      chk("done", 32'(done), 32'(c == done_at));
      chk("core_hold", 32'(core_hold), 32'(c != done_at));
      if (c == done_at || done) begin
        saw_done = 1'b1;
        done_c   = c;
      end
      if (!saw_done && abort_after > 0 && writes == abort_after && !mem_we) begin
        rst = 1'b1; byte_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_addr", 32'(mem_addr), 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        chk("abort_hold", 32'(core_hold), 32'd0);
        chk("abort_ready", 32'(byte_ready), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        quiet = 0;
        for (int k = 0; k < 30; k++) begin
          byte_valid = k[0];
          byte_data  = 8'(k);
          tick();
          if (mem_we || done) quiet++;
        end
        byte_valid = 1'b0;
        chk("abort_quiet", 32'(quiet), 32'd0);
        chk("abort_writes", 32'(writes), 32'(abort_after));
        return;
      end
      if (!saw_done) begin
        case (mode)
          0:       bv = 1'b1;
          1:       bv = c[0];
          default: bv = 1'($urandom_range(0, 1));
        endcase
        if (ptr < 4 * len) byte_data = byte_q[ptr];
        else if (c_CK_EN && !ck_sent) byte_data = ck;
        else bv = 1'b0;
        byte_valid = bv;
        if (bv && byte_ready) begin
          if (ptr < 4 * len) ptr++;
          else begin
            ck_sent = 1'b1;
            done_at = c + 1;
          end
        end
        tick();
        c++;
      end
    end
    byte_valid = 1'b0;
    if (!saw_done) chk("timeout", 32'(c), 32'(budget));
    chk("write_count", 32'(writes), 32'(len));
    if (mode == 0) chk("latency", 32'(done_c), 32'(5 * len + ((c_CK_EN && len > 0) ? 1 : 0)));
    exp_err = c_CK_EN && bad_ck && (len > 0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("hold_after", 32'(core_hold), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("idle_no_we", 32'(mem_we), 32'd0);
      chk("err_sticky", 32'(err), 32'(exp_err));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_len = 9'd0; byte_valid = 1'b0; byte_data = 8'd0;
    tick();
    tick();
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_hold", 32'(core_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    rst = 1'b1; start = 1'b1; load_len = 9'd5;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_hold", 32'(core_hold), 32'd0);
    tick();
    chk("rst_prio_ready", 32'(byte_ready), 32'd0);
    chk("rst_prio_done", 32'(done), 32'd0);

    byte_q = '{8'h83, 8'hB1, 8'h07, 8'h00};
    run_session(1, 0, 0, 1'b0);

    fill_random(3);
    run_session(3, 1, 0, 1'b0);

    byte_q.delete();
    run_session(0, 0, 0, 1'b0);

    fill_incr(256);
    run_session(256, 0, 0, 1'b0);

    fill_random(4);
    run_session(4, 0, 2, 1'b0);
    fill_random(1);
    run_session(1, 2, 0, 1'b0);

    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(1, 0, 0, 1'b0);
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(1, 0, 0, 1'b1);

    for (int s = 0; s < 8; s++) begin
      int len;
      len = int'($urandom_range(1, 8));
      fill_random(len);
      run_session(len, int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
